pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. Each cycle it produces the fetch address `pc` and instruction-memory enable `ce`, as the next generation of the basic PC register. It adds pipeline stall, branch redirect with capture of a redirect that arrives while stalled, and an optional exception/flush redirect. It sits between the control unit (stall/flush), the decode stage (branch) and instruction ROM.

## Interface
- `ADDR_W`, 32, PC / address width in bits (≥ 8).
- `RESET_VECTOR`, `ADDR_W'h0`, first fetch address after reset; low 2 bits must be 0.
- `PC_STEP`, 4, sequential increment in bytes.

- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable` = 1'b1).
- `stall`  in  1  hold PC this cycle (fetch stage stalled).
- `branch_flag_i`  in  1  decode requests redirect.
- `branch_target_addr_i`  in  `ADDR_W`  redirect target.
- `flush`  in  1  exception/ERET redirect (only with `PC_FLUSH_EN`).
- `new_pc`  in  `ADDR_W`  flush target (only with `PC_FLUSH_EN`).
- `pc`  out  `ADDR_W`  current fetch address, registered.
- `ce`  out  1  instruction-memory chip enable (`ChipEnable`/`ChipDisable`), registered.
- `redirect_pending_o`  out  1  a branch captured during stall awaits application.

## Operation
- Registers: `ce`, `pc`, `pend_valid`, `pend_addr[ADDR_W-1:0]`.
- Reset (`rst`=1 at edge): `ce`←0, `pc`←`RESET_VECTOR`, `pend_valid`←0, `pend_addr`←0.
- `ce`←1 on every edge with `rst`=0.
- `pc` next-state priority at each edge (first match wins):
  1. `rst`: `RESET_VECTOR`.
  2. `ce`=0: `RESET_VECTOR` (first enabled cycle fetches the vector).
  3. `flush` (macro on): `new_pc`; also clears `pend_valid`.
  4. `stall`: hold `pc`; if `branch_flag_i`, `pend_valid`←1, `pend_addr`←target (latest wins).
  5. `pend_valid`: `pend_addr`; `pend_valid`←0. A concurrent `branch_flag_i` is loaded into pend (new redirect overrides old only on next cycle).
  6. `branch_flag_i`: `branch_target_addr_i`.
  7. else: `pc + PC_STEP`, modulo 2^`ADDR_W` (wraps silently, no flag).
- All loaded addresses have bits [1:0] forced to 0.
- `redirect_pending_o` = `pend_valid`.

## Timing
- Redirect latency: branch asserted in cycle N (no stall) → `pc`=target in N+1.
- Stalled branch: captured at edge; applied on first edge with `stall`=0; `pc` = target one cycle after stall release.
- Flush overrides stall and any pending branch in the same cycle; `pc`=`new_pc` next cycle.
- `rst` mid-operation: all state returns to reset values at that edge; pending redirect discarded.
- After `rst` falls: cycle 1 `ce`=1, `pc`=`RESET_VECTOR`; cycle 2 `pc`=`RESET_VECTOR+PC_STEP`.
- `stall` with `ce`=0 has no effect (pc stays at vector).

## Configuration
- `PC_FLUSH_EN` defined: `flush`/`new_pc` ports present, priority 3 active.
- Undefined: ports absent, priority 3 removed; only reset clears pending state.

## Structure
- Shared defines package: `RstEnable`, `ChipEnable`, `ChipDisable`, `InstAddrBus` width, default `RESET_VECTOR`, `PC_STEP`.
- Optional sub-module `pc_redirect_buf`: the `pend_valid`/`pend_addr` capture/apply register; everything else inline.

## Test plan
- Reset release, `RESET_VECTOR`=0 → `ce` 0→1 one cycle after `rst` falls; `pc` sequence 0x0, 0x4, 0x8, 0xC.
- Branch at pc=0x10, target 0x100, no stall → next `pc`=0x100, then 0x104.
- `stall` 3 cycles at pc=0x20, branch to 0x200 in stall cycle 2 → `pc` holds 0x20, `redirect_pending_o`=1, `pc`=0x200 one cycle after release, pending clears.
- Flush (macro on) with `new_pc`=0x180 during stall with pending 0x200 → `pc`=0x180, pending cleared, 0x200 never fetched.
- `ADDR_W`=8, pc=0xFC → next `pc`=0x00; target 0x43 → loaded as 0x40.
- `rst` asserted with pending redirect → `pc`=vector, `ce`=0, `redirect_pending_o`=0 next cycle.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the instruction-fetch program-counter generator.
// Provides reset/chip-enable encodings, default address-bus width, default
// reset vector and default sequential step.
package pc_gen_pkg;

    localparam int unsigned InstAddrBus = 32;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [InstAddrBus-1:0] DefResetVector = '0;
    localparam int unsigned            DefPcStep      = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a branch redirect that arrived while fetch was
// stalled, until it can be applied.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   load_i          - capture addr_i (wins over clear_i in the same cycle)
//   clear_i         - drop the held redirect
//   addr_i          - redirect address to capture (already word aligned)
//   pend_valid_o    - a redirect is held
//   pend_addr_o     - held redirect address
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              pend_valid_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;

    // Load overrides clear so a branch arriving as an old redirect is
    // consumed becomes the next pending redirect.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (load_i) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = addr_i;
        end else if (clear_i) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_addr_o  = pend_addr_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the instruction-fetch stage.
// Produces the registered fetch address and instruction-memory enable,
// handling stall, branch redirect (captured if it arrives during a stall)
// and, when PC_FLUSH_EN is defined, an exception/flush redirect.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   stall                 - hold pc this cycle
//   branch_flag_i         - decode requests a redirect
//   branch_target_addr_i  - redirect target
//   flush, new_pc         - flush redirect and its target (PC_FLUSH_EN only)
//   pc                    - current fetch address
//   ce                    - instruction-memory chip enable
//   redirect_pending_o    - a stalled branch awaits application
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter int unsigned       PC_STEP      = DefPcStep
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_addr_i,
`ifdef PC_FLUSH_EN
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending_o
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_c;
    logic [ADDR_W-1:0] new_pc_c;
    logic              pend_load_c, pend_clear_c;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] target_c;

`ifdef PC_FLUSH_EN
    assign flush_c  = flush;
    assign new_pc_c = new_pc;
`else
    assign flush_c  = 1'b0;
    assign new_pc_c = '0;
`endif

    assign target_c = branch_target_addr_i & AlignMask;

    // Next-pc priority chain; reset is handled in the register stage.
    always_comb begin
        ce_d         = ChipEnable;
        pc_d         = pc_q;
        pend_load_c  = 1'b0;
        pend_clear_c = 1'b0;
        if (ce_q == ChipDisable) begin
            pc_d = RESET_VECTOR;
        end else if (flush_c) begin
            pc_d         = new_pc_c;
            pend_clear_c = 1'b1;
        end else if (stall) begin
            pend_load_c = branch_flag_i;
        end else if (pend_valid) begin
            pc_d         = pend_addr;
            pend_clear_c = 1'b1;
            pend_load_c  = branch_flag_i;
        end else if (branch_flag_i) begin
            pc_d = target_c;
        end else begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        pc_d = pc_d & AlignMask;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_q <= ChipDisable;
            pc_q <= RESET_VECTOR;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk          (clk),
        .rst          (rst),
        .load_i       (pend_load_c),
        .clear_i      (pend_clear_c),
        .addr_i       (target_c),
        .pend_valid_o (pend_valid),
        .pend_addr_o  (pend_addr)
    );

    assign pc                 = pc_q;
    assign ce                 = ce_q;
    assign redirect_pending_o = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, hand sequences (flush,
// 8-bit wrap/alignment) and randomized traffic against a reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] pc;
    logic        ce;
    logic        pend;

    logic        rst8 = 1'b1;
    logic        br8 = 1'b0;
    logic [7:0]  tgt8 = '0;
    logic [7:0]  pc8;
    logic        ce8;
    logic        pend8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'h0),
        .PC_STEP      (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .branch_flag_i        (br),
        .branch_target_addr_i (tgt),
`ifdef PC_FLUSH_EN
        .flush                (flush),
        .new_pc               (new_pc),
`endif
        .pc                   (pc),
        .ce                   (ce),
        .redirect_pending_o   (pend)
    );

    pc_gen #(
        .ADDR_W       (8),
        .RESET_VECTOR (8'h00),
        .PC_STEP      (4)
    ) dut8 (
        .clk                  (clk),
        .rst                  (rst8),
        .stall                (1'b0),
        .branch_flag_i        (br8),
        .branch_target_addr_i (tgt8),
`ifdef PC_FLUSH_EN
        .flush                (1'b0),
        .new_pc               (8'h00),
`endif
        .pc                   (pc8),
        .ce                   (ce8),
        .redirect_pending_o   (pend8)
    );

    // Reference model of the 32-bit instance, kept as plain variables and a
    // queue holding at most one pending redirect.
    logic        m_ce = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_pend[$];

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_edge();
        logic old_ce;
        logic fl;
`ifdef PC_FLUSH_EN
        fl = flush;
`else
        fl = 1'b0;
`endif
        if (rst) begin
            m_ce = 1'b0;
            m_pc = 32'h0;
            m_pend.delete();
            return;
        end
        old_ce = m_ce;
        m_ce   = 1'b1;
        if (!old_ce) begin
            m_pc = 32'h0;
        end else if (fl) begin
            m_pc = al(new_pc);
            m_pend.delete();
        end else if (stall) begin
            if (br) begin
                m_pend.delete();
                m_pend.push_back(al(tgt));
            end
        end else if (m_pend.size() > 0) begin
            m_pc = m_pend.pop_front();
            if (br) m_pend.push_back(al(tgt));
        end else if (br) begin
            m_pc = al(tgt);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge,
    // then settle before any sampling.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic [31:0] p,
                                input logic c, input logic pe);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t;
        v.pc = p; v.ce = c; v.pend = pe;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        // rst stall br tgt | pc ce pend (after the edge)
        tbl[0]  = mk(1, 0, 0, 32'h0,   32'h0,   0, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,   32'h4,   1, 0);
        tbl[3]  = mk(0, 0, 0, 32'h0,   32'h8,   1, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,   32'hC,   1, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,   32'h10,  1, 0);
        tbl[6]  = mk(0, 0, 1, 32'h100, 32'h100, 1, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,   32'h104, 1, 0);
        tbl[8]  = mk(0, 0, 1, 32'h20,  32'h20,  1, 0);
        tbl[9]  = mk(0, 1, 0, 32'h0,   32'h20,  1, 0);
        tbl[10] = mk(0, 1, 1, 32'h200, 32'h20,  1, 1);
        tbl[11] = mk(0, 1, 0, 32'h0,   32'h20,  1, 1);
        tbl[12] = mk(0, 0, 0, 32'h0,   32'h200, 1, 0);
        tbl[13] = mk(0, 0, 0, 32'h0,   32'h204, 1, 0);
        tbl[14] = mk(0, 1, 1, 32'h300, 32'h204, 1, 1);
        tbl[15] = mk(0, 1, 1, 32'h344, 32'h204, 1, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,   32'h344, 1, 0);
        tbl[17] = mk(0, 1, 1, 32'h400, 32'h344, 1, 1);
        tbl[18] = mk(0, 0, 1, 32'h500, 32'h400, 1, 1);
        tbl[19] = mk(0, 0, 0, 32'h0,   32'h500, 1, 0);
        tbl[20] = mk(0, 0, 0, 32'h0,   32'h504, 1, 0);
        tbl[21] = mk(0, 0, 1, 32'h613, 32'h610, 1, 0);
        tbl[22] = mk(0, 1, 1, 32'h700, 32'h610, 1, 1);
        tbl[23] = mk(1, 0, 0, 32'h0,   32'h0,   0, 0);
        tbl[24] = mk(0, 1, 0, 32'h0,   32'h0,   1, 0);
        tbl[25] = mk(0, 0, 0, 32'h0,   32'h4,   1, 0);

        // Directed table on the 32-bit instance.
        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall; br = tbl[i].br; tgt = tbl[i].tgt;
            tick();
            check($sformatf("tbl%0d.pc", i), pc, tbl[i].pc);
            check($sformatf("tbl%0d.ce", i), 32'(ce), 32'(tbl[i].ce));
            check($sformatf("tbl%0d.pend", i), 32'(pend), 32'(tbl[i].pend));
        end
        stall = 1'b0; br = 1'b0;

`ifdef PC_FLUSH_EN
        // Flush during stall with a pending redirect wins over both.
        br = 1'b1; tgt = 32'h20; tick();
        check("fl.setup", pc, 32'h20);
        stall = 1'b1; tgt = 32'h200; tick();
        check("fl.pend", 32'(pend), 32'd1);
        br = 1'b0; flush = 1'b1; new_pc = 32'h180; tick();
        check("fl.pc", pc, 32'h180);
        check("fl.pendclr", 32'(pend), 32'd0);
        flush = 1'b0; stall = 1'b0; tick();
        check("fl.next", pc, 32'h184);
`endif

        // 8-bit instance: wraparound and target alignment.
        rst8 = 1'b1; tick();
        check("w8.rst.ce", 32'(ce8), 32'd0);
        rst8 = 1'b0; tick();
        check("w8.vec", 32'(pc8), 32'h00);
        br8 = 1'b1; tgt8 = 8'hFC; tick();
        check("w8.fc", 32'(pc8), 32'hFC);
        br8 = 1'b0; tick();
        check("w8.wrap", 32'(pc8), 32'h00);
        br8 = 1'b1; tgt8 = 8'h43; tick();
        check("w8.align", 32'(pc8), 32'h40);
        check("w8.pend", 32'(pend8), 32'd0);
        br8 = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) < 2);
            stall  = ($urandom_range(0, 99) < 30);
            br     = ($urandom_range(0, 99) < 25);
            tgt    = $urandom();
            flush  = ($urandom_range(0, 99) < 5);
            new_pc = $urandom();
            tick();
            check($sformatf("rnd%0d.pc", i), pc, m_pc);
            check($sformatf("rnd%0d.ce", i), 32'(ce), 32'(m_ce));
            check($sformatf("rnd%0d.pend", i), 32'(pend), 32'(m_pend.size() != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
